// File: rtl/limb_master_if.sv
// -----------------------------------------------------------------------------
// limb_master_if
// Bundles the command/response handshake and the LIMB byte bus of limb_master.
//   cmd_*      : command offer (valid/ready), direction, sequential hint,
//                36-bit word address, 32-bit write data
//   rsp_*      : one-cycle completion pulse, timeout flag, read data
//   limb_d_*   : split byte bus; the chip top merges d_out/d_oe/d_in into
//                a single inout pad
//   limb_start : address-phase marker, limb_nrd: 0=read, limb_nwait: 0=busy
//   busy       : master is not idle
// Modport 'master' is the limb_master side; 'slave' is the opposite side.
// -----------------------------------------------------------------------------
interface limb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic        cmd_seq;
  logic [35:0] cmd_adr;
  logic [31:0] cmd_dat;

  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_dat;

  logic [7:0]  limb_d_out;
  logic        limb_d_oe;
  logic [7:0]  limb_d_in;
  logic        limb_start;
  logic        limb_nrd;
  logic        limb_nwait;

  logic        busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_seq, cmd_adr, cmd_dat, limb_d_in, limb_nwait,
    output cmd_ready, rsp_valid, rsp_err, rsp_dat,
           limb_d_out, limb_d_oe, limb_start, limb_nrd, busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_seq, cmd_adr, cmd_dat, limb_d_in, limb_nwait,
    input  cmd_ready, rsp_valid, rsp_err, rsp_dat,
           limb_d_out, limb_d_oe, limb_start, limb_nrd, busy
  );
endinterface

// File: rtl/limb_master.sv
// -----------------------------------------------------------------------------
// limb_master
// Byte-wide LIMB bus master. Accepts one command at a time, sends a 5-byte
// address phase (skipped for eligible sequential accesses), then 4 write bytes
// or a read turnaround, waits on the slave's nwait handshake with a timeout,
// collects 4 read bytes, and emits a one-cycle response.
// Ports:
//   limb_clk   : clock
//   reset      : synchronous, active-high reset
//   m          : limb_master_if.master (command, response and LIMB bus)
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles with nwait low before the access is aborted
//   SYNC_STAGES    : depth of the limb_nwait synchronizer
// All bus, handshake and response outputs come straight from flops.
// -----------------------------------------------------------------------------
module limb_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          limb_clk,
  input  logic          reset,
  limb_master_if.master m
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [4:0] {
    S_IDLE,
    S_ADR0, S_ADR1, S_ADR2, S_ADR3, S_ADR4,
    S_WDAT0, S_WDAT1, S_WDAT2, S_WDAT3,
    S_RTURN, S_GUARD, S_WAIT,
    S_RDAT0, S_RDAT1, S_RDAT2, S_RDAT3,
    S_DONE
  } state_t;

  // FSM and transaction context
  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [35:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [23:0]        rd_buf_q, rd_buf_d;

  // Record of the last completed transaction for sequential continuation
  logic               prev_vld_q, prev_vld_d;
  logic               prev_we_q, prev_we_d;
  logic [35:0]        prev_adr_q, prev_adr_d;

  // Registered outputs
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic               nrd_q, nrd_d;
  logic               oe_q, oe_d;
  logic [7:0]         dout_q, dout_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;

  logic [SYNC_STAGES-1:0] nwait_sync_q;
  logic                   nwait_s;
  logic                   seq_ok;
  logic                   timeout;

  assign nwait_s = nwait_sync_q[SYNC_STAGES-1];

  // Skip the address phase only when the slave's auto-incremented address is
  // known to match: same direction, low byte +1 without carry into [35:8].
  assign seq_ok = m.cmd_seq && prev_vld_q && (m.cmd_we == prev_we_q) &&
                  (m.cmd_adr[7:0] == prev_adr_q[7:0] + 8'd1) &&
                  (m.cmd_adr[35:8] == prev_adr_q[35:8]);

  // ---------------------------------------------------------------------------
  // Next-state and context logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    cnt_d      = cnt_q;
    rd_buf_d   = rd_buf_q;
    rsp_dat_d  = rsp_dat_q;
    prev_vld_d = prev_vld_q;
    prev_we_d  = prev_we_q;
    prev_adr_d = prev_adr_q;
    timeout    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m.cmd_valid) begin
          we_d  = m.cmd_we;
          adr_d = m.cmd_adr;
          dat_d = m.cmd_dat;
          if (seq_ok) state_d = m.cmd_we ? S_WDAT0 : S_RTURN;
          else        state_d = S_ADR0;
        end
      end
      S_ADR0:  state_d = S_ADR1;
      S_ADR1:  state_d = S_ADR2;
      S_ADR2:  state_d = S_ADR3;
      S_ADR3:  state_d = S_ADR4;
      S_ADR4:  state_d = we_q ? S_WDAT0 : S_RTURN;
      S_WDAT0: state_d = S_WDAT1;
      S_WDAT1: state_d = S_WDAT2;
      S_WDAT2: state_d = S_WDAT3;
      S_WDAT3: state_d = S_GUARD;
      S_RTURN: state_d = S_GUARD;
      S_GUARD: begin
        // nwait is ignored here: the slave needs a cycle to drop its ready flag
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (nwait_s) begin
          state_d = we_q ? S_DONE : S_RDAT0;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RDAT0: begin rd_buf_d[7:0]   = m.limb_d_in; state_d = S_RDAT1; end
      S_RDAT1: begin rd_buf_d[15:8]  = m.limb_d_in; state_d = S_RDAT2; end
      S_RDAT2: begin rd_buf_d[23:16] = m.limb_d_in; state_d = S_RDAT3; end
      S_RDAT3: begin
        // Publish the whole word at once so rsp_dat only changes on completion
        rsp_dat_d = {m.limb_d_in, rd_buf_q};
        state_d   = S_DONE;
      end
      S_DONE: begin
        prev_vld_d = ~rsp_err_q;
        prev_we_d  = we_q;
        prev_adr_d = adr_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the upcoming state, so the registered outputs line up
  // with the state they belong to. Uses the _d context because the first
  // address/data byte must appear on the accept edge itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    start_d     = 1'b0;
    nrd_d       = 1'b1;
    oe_d        = 1'b1;
    dout_d      = 8'h00;
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    rsp_err_d   = timeout;

    case (state_d)
      S_ADR0:  begin start_d = 1'b1; dout_d = adr_d[7:0]; end
      S_ADR1:  dout_d = adr_d[15:8];
      S_ADR2:  dout_d = adr_d[23:16];
      S_ADR3:  dout_d = adr_d[31:24];
      S_ADR4:  dout_d = {4'b0000, adr_d[35:32]};
      S_WDAT0: dout_d = dat_d[7:0];
      S_WDAT1: dout_d = dat_d[15:8];
      S_WDAT2: dout_d = dat_d[23:16];
      S_WDAT3: dout_d = dat_d[31:24];
      S_RTURN, S_RDAT0, S_RDAT1, S_RDAT2, S_RDAT3: begin
        nrd_d = 1'b0;
        oe_d  = 1'b0;
      end
      // Read keeps the bus released until the response; write keeps driving
      S_GUARD, S_WAIT, S_DONE: begin
        nrd_d = we_d;
        oe_d  = we_d;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, context and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge limb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      cnt_q       <= '0;
      rd_buf_q    <= '0;
      prev_vld_q  <= 1'b0;
      prev_we_q   <= 1'b0;
      prev_adr_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      nrd_q       <= 1'b1;
      oe_q        <= 1'b1;
      dout_q      <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      rd_buf_q    <= rd_buf_d;
      prev_vld_q  <= prev_vld_d;
      prev_we_q   <= prev_we_d;
      prev_adr_q  <= prev_adr_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      nrd_q       <= nrd_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  // nwait synchronizer; resets to "ready" so no stale busy is seen after reset
  always_ff @(posedge limb_clk) begin
    if (reset) begin
      nwait_sync_q <= '1;
    end else begin
      nwait_sync_q[0] <= m.limb_nwait;
      for (int i = 1; i < SYNC_STAGES; i++) nwait_sync_q[i] <= nwait_sync_q[i-1];
    end
  end

  assign m.cmd_ready  = cmd_ready_q;
  assign m.busy       = busy_q;
  assign m.limb_start = start_q;
  assign m.limb_nrd   = nrd_q;
  assign m.limb_d_oe  = oe_q;
  assign m.limb_d_out = dout_q;
  assign m.rsp_valid  = rsp_valid_q;
  assign m.rsp_err    = rsp_err_q;
  assign m.rsp_dat    = rsp_dat_q;

endmodule

// File: tb/tb_limb_master.sv
// -----------------------------------------------------------------------------
// tb_limb_master
// Directed bench for limb_master: one instance with default parameters and a
// second with TIMEOUT_CYCLES=8 for the abort path. Expected values are
// hand-computed cycle positions and bytes; cycle 1 is the cycle right after
// the accepting edge.
// -----------------------------------------------------------------------------
module tb_limb_master;

  logic limb_clk = 1'b0;
  logic reset;
  always #5 limb_clk = ~limb_clk;

  limb_master_if bus();
  limb_master_if bus_to();

  limb_master dut (
    .limb_clk (limb_clk),
    .reset    (reset),
    .m        (bus.master)
  );

  limb_master #(.TIMEOUT_CYCLES(8)) dut_to (
    .limb_clk (limb_clk),
    .reset    (reset),
    .m        (bus_to.master)
  );

  int checks = 0;
  int errors = 0;

  // Per-transaction observations filled by wait_rsp
  int          lat, n_start, n_oe_bad, n_rdy, n_busy_low;
  logic [63:0] start_log, oe_log, nrd_log;
  logic [7:0]  dout_log [0:63];

  // Scheduled slave behaviour: release nwait at cycle rd_rel, then present
  // rd_bytes so they land in RDAT0..RDAT3 (2 sync stages + 1 exit cycle).
  int          rd_rel = 0;
  logic [7:0]  rd_bytes [0:3];
  logic [7:0]  exp_wr   [0:8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge limb_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {bus.cmd_ready, bus.busy, bus.limb_start, bus.limb_nrd,
                          bus.limb_d_oe, bus.rsp_valid, bus.rsp_err}, 7'b1001100);
    check({tag, "_dout"}, bus.limb_d_out, 8'h00);
    check({tag, "_rdat"}, bus.rsp_dat, 32'h0);
  endtask

  task automatic issue(input logic we, input logic seq, input logic [35:0] adr,
                       input logic [31:0] dat);
    bus.cmd_we    = we;
    bus.cmd_seq   = seq;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_valid = 1'b1;
    tick;
    bus.cmd_valid = 1'b0;
  endtask

  // Called in cycle 1; runs until rsp_valid or the bound expires.
  task automatic wait_rsp(input int bound);
    lat = 0; n_start = 0; n_oe_bad = 0; n_rdy = 0; n_busy_low = 0;
    start_log = '0; oe_log = '0; nrd_log = '0;
    for (int n = 1; n <= bound; n++) begin
      if (n < 64) begin
        dout_log[n]  = bus.limb_d_out;
        start_log[n] = bus.limb_start;
        oe_log[n]    = bus.limb_d_oe;
        nrd_log[n]   = bus.limb_nrd;
      end
      if (bus.limb_start) n_start++;
      if (!bus.limb_nrd && bus.limb_d_oe) n_oe_bad++;
      if (bus.cmd_ready) n_rdy++;
      if (!bus.busy) n_busy_low++;
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
      if (rd_rel != 0) begin
        if (n == rd_rel) bus.limb_nwait = 1'b1;
        for (int k = 0; k < 4; k++)
          if (n == rd_rel + 3 + k) bus.limb_d_in = rd_bytes[k];
      end
      tick;
    end
    check("rsp_seen", (lat != 0), 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cnt;
    int n_to;

    exp_wr = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h09, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rd_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_seq = 1'b0;
    bus.cmd_adr = '0; bus.cmd_dat = '0;
    bus.limb_d_in = 8'hEE; bus.limb_nwait = 1'b1;
    bus_to.cmd_valid = 1'b0; bus_to.cmd_we = 1'b0; bus_to.cmd_seq = 1'b0;
    bus_to.cmd_adr = '0; bus_to.cmd_dat = '0;
    bus_to.limb_d_in = 8'h00; bus_to.limb_nwait = 1'b0;

    repeat (3) tick;
    check_idle("reset");
    reset = 1'b0;
    tick;

    // Full write, zero wait
    issue(1'b1, 1'b0, 36'h9_1234_5678, 32'hDEADBEEF);
    wait_rsp(40);
    check("wr_lat", lat, 12);
    check("wr_starts", n_start, 1);
    check("wr_start_c1", start_log[1], 1'b1);
    for (int i = 0; i < 9; i++) check($sformatf("wr_dout%0d", i), dout_log[i+1], exp_wr[i]);
    check("wr_err", bus.rsp_err, 1'b0);
    check("wr_rdy_busy", n_rdy + n_busy_low, 0);
    tick;
    check("wr_pulse", {bus.rsp_valid, bus.cmd_ready}, 2'b01);

    // Full read, nwait low for 20 cycles
    bus.limb_nwait = 1'b0;
    rd_rel = 20;
    issue(1'b0, 1'b0, 36'h0_0000_0010, 32'h0);
    wait_rsp(60);
    rd_rel = 0;
    bus.limb_d_in = 8'hEE;
    check("rd_lat", lat, 27);
    check("rd_dat", bus.rsp_dat, 32'h44332211);
    check("rd_err", bus.rsp_err, 1'b0);
    check("rd_oe_log", oe_log[27:1], 27'h1F);
    check("rd_nrd_log", nrd_log[27:1], 27'h1F);
    check("rd_oe_bad", n_oe_bad, 0);
    tick;
    check("rd_idle_bus", {bus.limb_nrd, bus.limb_d_oe, bus.rsp_valid}, 3'b110);
    check("rd_hold", bus.rsp_dat, 32'h44332211);

    // Sequential writes: byte carry forces full address, then true seq
    issue(1'b1, 1'b0, 36'h0FF, 32'h1);
    wait_rsp(40);
    check("s0_lat", lat, 12);
    tick;
    issue(1'b1, 1'b1, 36'h100, 32'h2);
    wait_rsp(40);
    check("carry_lat", lat, 12);
    check("carry_start", start_log[1], 1'b1);
    check("carry_adr", {dout_log[1], dout_log[2]}, 16'h0001);
    tick;
    issue(1'b1, 1'b1, 36'h101, 32'h76543210);
    wait_rsp(40);
    check("seq_lat", lat, 7);
    check("seq_starts", n_start, 0);
    check("seq_wdat", {dout_log[1], dout_log[2], dout_log[3], dout_log[4]}, 32'h10325476);
    tick;
    check("rd_held_wr", bus.rsp_dat, 32'h44332211);

    // Reads: full, sequential, then direction change breaks the sequence
    issue(1'b0, 1'b0, 36'h20, 32'h0);
    wait_rsp(40);
    check("rd2_lat", lat, 13);
    check("rd2_dat", bus.rsp_dat, 32'hEEEEEEEE);
    tick;
    issue(1'b0, 1'b1, 36'h21, 32'h0);
    wait_rsp(40);
    check("seqrd_lat", lat, 8);
    check("seqrd_starts", n_start, 0);
    tick;
    issue(1'b1, 1'b1, 36'h22, 32'h0);
    wait_rsp(40);
    check("dir_lat", lat, 12);
    check("dir_start", start_log[1], 1'b1);
    tick;

    // Reset in WAIT (read at 0x30 enters WAIT in cycle 8)
    bus.limb_nwait = 1'b0;
    issue(1'b0, 1'b0, 36'h30, 32'h0);
    repeat (11) tick;
    check("pre_rst_busy", bus.busy, 1'b1);
    reset = 1'b1;
    tick;
    check_idle("rst_wait");
    reset = 1'b0;
    bus.limb_nwait = 1'b1;
    cnt = 0;
    repeat (20) begin tick; if (bus.rsp_valid) cnt++; end
    check("rst_wait_norsp", cnt, 0);

    // Reset cleared the sequential record: 0x23 after the 0x22 write is full
    issue(1'b1, 1'b1, 36'h23, 32'h0);
    wait_rsp(40);
    check("rst_seq_lat", lat, 12);
    check("rst_seq_start", start_log[1], 1'b1);
    tick;

    // Reset in WDAT2 (cycle 8 of a full write)
    issue(1'b1, 1'b0, 36'h40, 32'hCAFEF00D);
    repeat (7) tick;
    check("wdat2_dout", bus.limb_d_out, 8'hFE);
    reset = 1'b1;
    tick;
    check_idle("rst_wdat2");
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin tick; if (bus.rsp_valid) cnt++; end
    check("rst_wdat2_norsp", cnt, 0);

    // cmd_valid held high across a whole transaction
    bus.cmd_we = 1'b1; bus.cmd_seq = 1'b0; bus.cmd_adr = 36'h50; bus.cmd_dat = 32'h5;
    bus.cmd_valid = 1'b1;
    tick;
    wait_rsp(40);
    check("hold_lat", lat, 12);
    check("hold_starts", n_start, 1);
    check("hold_rdy", n_rdy, 0);
    tick;
    check("hold_idle", {bus.cmd_ready, bus.busy}, 2'b10);
    bus.cmd_valid = 1'b0;
    tick;
    check("hold_no_reaccept", {bus.busy, bus.limb_start}, 2'b00);

    // Timeout instance: nwait stuck low, 8 WAIT cycles then error response
    bus_to.cmd_we = 1'b1; bus_to.cmd_seq = 1'b0; bus_to.cmd_adr = 36'h55; bus_to.cmd_dat = 32'h1;
    bus_to.cmd_valid = 1'b1;
    tick;
    bus_to.cmd_valid = 1'b0;
    n_to = 0;
    for (int n = 1; n <= 60; n++) begin
      if (bus_to.rsp_valid) begin n_to = n; break; end
      tick;
    end
    check("to_lat", n_to, 19);
    check("to_err", bus_to.rsp_err, 1'b1);
    tick;
    check("to_err_clr", {bus_to.rsp_valid, bus_to.rsp_err}, 2'b00);
    bus_to.cmd_seq = 1'b1; bus_to.cmd_adr = 36'h56;
    bus_to.cmd_valid = 1'b1;
    tick;
    bus_to.cmd_valid = 1'b0;
    check("to_seq_start", bus_to.limb_start, 1'b1);
    check("to_seq_adr0", bus_to.limb_d_out, 8'h56);
    n_to = 0;
    for (int n = 1; n <= 60; n++) begin
      if (bus_to.rsp_valid) begin n_to = n; break; end
      tick;
    end
    check("to2_lat", n_to, 19);
    check("to2_err", bus_to.rsp_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
